// File: rtl/sram_responder_if.sv
// sram_responder_if: initiator-side cs/we/oe/address strobes plus the target's rd_valid
interface sram_responder_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] address;
  logic cs;
  logic we;
  logic oe;
  logic rd_valid;
  modport master (output address, cs, we, oe, input rd_valid);
  modport slave (input address, cs, we, oe, output rd_valid);
endinterface

// File: rtl/sram_responder.sv
// sram_responder: SRAM target, 1-cycle read latency on tri-state data, sticky err, saturating wr_cnt; SRAM_INIT_CLEAR_EN adds a post-reset zeroing sweep
module sram_responder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4,
  parameter int DEPTH = 256
) (
  input logic clk,
  input logic reset,
  sram_responder_if.slave bus,
  inout wire [DATA_W-1:0] data,
  output logic [ADDR_W:0] wr_cnt,
  output logic err,
  output logic busy
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
`ifdef SRAM_INIT_CLEAR_EN
  typedef enum logic [2:0] {IDLE, WRITE, READ, ILLEGAL, CLEAR} state_t;
  localparam state_t RST_STATE = CLEAR;
  logic [AW-1:0] clr_q, clr_d;
`else
  typedef enum logic [1:0] {IDLE, WRITE, READ, ILLEGAL} state_t;
  localparam state_t RST_STATE = IDLE;
`endif
  state_t state_q, state_d, op_state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q, rd_d;
  logic [ADDR_W:0] wr_cnt_q, wr_cnt_d;
  logic err_q, err_d;
  logic mem_we;
  logic [AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic in_range;
  logic drive;
  assign in_range = {1'b0, bus.address} < (ADDR_W+1)'(DEPTH);
  assign op_state = !bus.cs ? IDLE : bus.we ? (bus.oe ? ILLEGAL : WRITE) : (bus.oe ? READ : IDLE);
  always_comb begin
    state_d = op_state;
    rd_d = rd_q;
    wr_cnt_d = wr_cnt_q;
    err_d = err_q;
    mem_we = 1'b0;
    mem_addr = bus.address[AW-1:0];
    mem_wdata = data;
`ifdef SRAM_INIT_CLEAR_EN
    clr_d = clr_q;
    if (state_q == CLEAR) begin
      state_d = clr_q == AW'(DEPTH-1) ? IDLE : CLEAR;
      clr_d = clr_q + 1'b1;
      mem_we = 1'b1;
      mem_addr = clr_q;
      mem_wdata = '0;
      err_d = err_q | (bus.cs & (bus.we | bus.oe));
    end else
`endif
    begin
      mem_we = op_state == WRITE && in_range;
      wr_cnt_d = mem_we && !wr_cnt_q[ADDR_W] ? wr_cnt_q + 1'b1 : wr_cnt_q;
      rd_d = op_state == READ ? (in_range ? mem[mem_addr] : '0) : rd_q;
      err_d = err_q | (op_state == ILLEGAL) | ((op_state == WRITE || op_state == READ) && !in_range);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RST_STATE;
      wr_cnt_q <= '0;
      err_q <= 1'b0;
`ifdef SRAM_INIT_CLEAR_EN
      clr_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      wr_cnt_q <= wr_cnt_d;
      err_q <= err_d;
`ifdef SRAM_INIT_CLEAR_EN
      clr_q <= clr_d;
`endif
    end
    rd_q <= rd_d;
  end
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[mem_addr] <= mem_wdata;
  end
  assign drive = state_q == READ;
  assign bus.rd_valid = drive;
  assign data = drive & bus.cs & bus.oe & ~bus.we ? rd_q : 'z;
  assign wr_cnt = wr_cnt_q;
  assign err = err_q;
`ifdef SRAM_INIT_CLEAR_EN
  assign busy = state_q == CLEAR;
`else
  assign busy = 1'b0;
`endif
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed vector table, corner sequences and random traffic checked against a behavioural SRAM model
module tb_sram_responder;
  localparam int AW = 8;
  localparam int DW = 4;
  localparam int DEPTH = 240;
  localparam logic [DW-1:0] MARK = 4'h5;
`ifdef SRAM_INIT_CLEAR_EN
  localparam logic [DW-1:0] R12 = 4'h0;
`else
  localparam logic [DW-1:0] R12 = 4'h2;
`endif
  typedef struct {
    bit rst, c, w, o;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit rdv;
    int cnt;
    bit err;
    logic [DW-1:0] dat;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  sram_responder_if #(.ADDR_W(AW)) bus ();
  wire [DW-1:0] data;
  logic drv_en = 1'b1;
  logic [DW-1:0] drv_val = MARK;
  assign data = drv_en ? drv_val : 'z;
  logic [AW:0] wr_cnt;
  logic err;
  logic busy;
  sram_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus), .data(data), .wr_cnt(wr_cnt), .err(err), .busy(busy)
  );
  logic [DW-1:0] m_mem [2**AW];
  bit m_known [2**AW];
  bit m_rdv, m_rdk, m_err;
  logic [DW-1:0] m_rdq;
  int m_cnt;
  int checks = 0;
  int errors = 0;
  bit poke = 1'b0;
  vec_t tbl [14];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
`ifdef SRAM_INIT_CLEAR_EN
  task automatic clear_wait();
    int n = 0;
    chk("busy_after_reset", busy, 1);
    while (busy && n < 2*DEPTH) begin
      @(negedge clk);
      reset = 1'b0;
      bus.cs = poke && n == 3;
      bus.we = bus.cs;
      bus.oe = 1'b0;
      bus.address = 8'd7;
      drv_en = 1'b1;
      drv_val = bus.cs ? 4'hF : MARK;
      if (bus.cs) m_err = 1'b1;
      @(posedge clk);
      #1;
      n++;
      chk("clear_bus_released", data, drv_val);
    end
    poke = 1'b0;
    chk("clear_len", n, DEPTH);
    for (int i = 0; i < 2**AW; i++) begin
      m_mem[i] = '0;
      m_known[i] = 1'b1;
    end
    chk("clear_err", err, m_err);
    chk("clear_cnt", wr_cnt, 0);
  endtask
`endif
  task automatic step(input bit rst, input bit c, input bit w, input bit o, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit rd_op;
    rd_op = c & o & ~w;
    @(negedge clk);
    reset = rst;
    bus.cs = c;
    bus.we = w;
    bus.oe = o;
    bus.address = a;
    drv_val = w ? d : MARK;
    drv_en = !(rd_op && m_rdv);
    #3;
    if (rd_op && m_rdv) begin
      if (m_rdk) chk("pre_edge_read_data", data, m_rdq);
    end else chk("pre_edge_bus", data, drv_val);
    @(posedge clk);
    if (rst) begin
      m_rdv = 1'b0;
      m_cnt = 0;
      m_err = 1'b0;
    end else if (c && w && o) begin
      m_err = 1'b1;
      m_rdv = 1'b0;
    end else if (c && w) begin
      m_rdv = 1'b0;
      if (a < DEPTH) begin
        m_mem[a] = d;
        m_known[a] = 1'b1;
        if (m_cnt < 2**AW) m_cnt++;
      end else m_err = 1'b1;
    end else if (c && o) begin
      m_rdv = 1'b1;
      if (a < DEPTH) begin
        m_rdq = m_mem[a];
        m_rdk = m_known[a];
      end else begin
        m_rdq = '0;
        m_rdk = 1'b1;
        m_err = 1'b1;
      end
    end else m_rdv = 1'b0;
    drv_en = !rd_op || rst;
    #1;
    chk("rd_valid", bus.rd_valid, m_rdv);
    chk("wr_cnt", wr_cnt, m_cnt);
    chk("err", err, m_err);
    if (m_rdv) begin
      if (m_rdk) chk("read_data", data, m_rdq);
    end else chk("bus_released", data, drv_val);
`ifdef SRAM_INIT_CLEAR_EN
    if (rst) clear_wait();
`endif
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
  initial begin
    bus.cs = 1'b0;
    bus.we = 1'b0;
    bus.oe = 1'b0;
    bus.address = '0;
    m_rdv = 1'b0;
    m_rdk = 1'b0;
    m_err = 1'b0;
    m_cnt = 0;
    for (int i = 0; i < 2**AW; i++) m_known[i] = 1'b0;
    tbl[0] = '{1, 0, 0, 0, 8'd0, 4'd0, 0, 0, 0, MARK};
    tbl[1] = '{0, 1, 1, 0, 8'd3, 4'd9, 0, 1, 0, 4'd9};
    tbl[2] = '{0, 1, 1, 0, 8'd4, 4'd6, 0, 2, 0, 4'd6};
    tbl[3] = '{0, 1, 0, 1, 8'd3, 4'd0, 1, 2, 0, 4'd9};
    tbl[4] = '{0, 1, 0, 1, 8'd4, 4'd0, 1, 2, 0, 4'd6};
    tbl[5] = '{0, 1, 1, 0, 8'd3, 4'd2, 0, 3, 0, 4'd2};
    tbl[6] = '{0, 1, 0, 1, 8'd3, 4'd0, 1, 3, 0, 4'd2};
    tbl[7] = '{0, 0, 0, 0, 8'd3, 4'd0, 0, 3, 0, MARK};
    tbl[8] = '{0, 1, 0, 1, 8'd250, 4'd0, 1, 3, 1, 4'd0};
    tbl[9] = '{0, 1, 1, 1, 8'd4, 4'd1, 0, 3, 1, 4'd1};
    tbl[10] = '{0, 1, 0, 1, 8'd4, 4'd0, 1, 3, 1, 4'd6};
    tbl[11] = '{1, 1, 0, 1, 8'd4, 4'd0, 0, 0, 0, MARK};
    tbl[12] = '{0, 1, 0, 1, 8'd3, 4'd0, 1, 0, 0, R12};
    tbl[13] = '{0, 1, 0, 0, 8'd3, 4'd0, 0, 0, 0, MARK};
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].rst, tbl[i].c, tbl[i].w, tbl[i].o, tbl[i].a, tbl[i].d);
      chk($sformatf("vec%0d_rd_valid", i), bus.rd_valid, tbl[i].rdv);
      chk($sformatf("vec%0d_wr_cnt", i), wr_cnt, tbl[i].cnt);
      chk($sformatf("vec%0d_err", i), err, tbl[i].err);
      chk($sformatf("vec%0d_data", i), data, tbl[i].dat);
      chk($sformatf("vec%0d_busy", i), busy, 0);
    end
    step(1, 0, 0, 0, 0, 0);
    for (int a = 0; a < 34; a++) step(0, 1, 1, 0, AW'(a), 4'b1010);
    for (int a = 0; a < 34; a++) step(0, 1, 0, 1, AW'(a), 0);
    step(0, 0, 0, 0, 0, 0);
    chk("t1_wr_cnt", wr_cnt, 34);
    chk("t1_err", err, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int a = 0; a < 2**AW; a++) step(0, 1, 1, 0, AW'(a), DW'($urandom));
    chk("t2_wr_cnt_in_range_only", wr_cnt, DEPTH);
    step(0, 0, 0, 0, 0, 0);
    for (int a = 0; a < 2**AW; a++) step(0, 1, 0, 1, AW'(a), 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 8'd5, 4'h3);
    step(0, 1, 1, 1, 8'd5, 4'hC);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0);
    chk("t3_err_sticky", err, 1);
    step(0, 1, 0, 1, 8'd5, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("t3_err_cleared", err, 0);
    step(0, 1, 1, 0, 8'd245, 4'h7);
    chk("t5_oob_write_cnt", wr_cnt, 0);
    chk("t5_oob_write_err", err, 1);
    for (int i = 0; i < 300; i++) step(0, 1, 1, 0, AW'($urandom_range(0, DEPTH-1)), DW'($urandom));
    chk("t5_wr_cnt_saturated", wr_cnt, 2**AW);
`ifdef SRAM_INIT_CLEAR_EN
    poke = 1'b1;
    step(1, 0, 0, 0, 0, 0);
    chk("t6_poke_err", err, 1);
    for (int a = 0; a < DEPTH; a++) step(0, 1, 0, 1, AW'(a), 0);
`endif
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) == 0, 1'($urandom), 1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
